// File: rtl/pixel_pkg.sv
// Shared types for the pixel write path.
//   wr_state_t : frame writer FSM states
//   DIR_FWD/REV: row scan direction (0 = left-to-right, 1 = right-to-left)
package pixel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } wr_state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/serp_pos_tracker.sv
// Serpentine position tracker for the frame writer.
// Holds the current (x, y), scan direction and the raster base address of the
// current row, and exposes the linear address of the current pixel.
// Ports:
//   clk, n_rst      : clock, asynchronous active-low reset
//   clear_i         : return to (0,0), forward direction, row base 0
//   advance_i       : step to the next pixel in serpentine order
//   max_x_i/max_y_i : frame dimensions (already latched by the caller)
//   x_o, y_o, dir_o : current position and direction
//   row_end_o       : current pixel is the last one of its row
//   last_o          : current pixel is the last one of the frame
//   addr_o          : row_base + x, the raster address of the current pixel
module serp_pos_tracker
  import pixel_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 2 * SIZE
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [SIZE-1:0]   max_x_i,
  input  logic [SIZE-1:0]   max_y_i,
  output logic [SIZE-1:0]   x_o,
  output logic [SIZE-1:0]   y_o,
  output logic              dir_o,
  output logic              row_end_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  logic [SIZE-1:0]   x_q, x_d;
  logic [SIZE-1:0]   y_q, y_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;

  // A row ends at the far edge for the current direction; with max_x == 1
  // both conditions hold at x == 0, so every pixel is a row end.
  assign row_end_o = (dir_q == DIR_FWD) ? (x_q == (max_x_i - ONE)) : (x_q == '0);
  assign last_o    = row_end_o && (y_q == (max_y_i - ONE));
  // Row base accumulates max_x per row, so no multiplier is needed.
  assign addr_o    = row_base_q + ADDR_W'(x_q);

  assign x_o   = x_q;
  assign y_o   = y_q;
  assign dir_o = dir_q;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    row_base_d = row_base_q;
    if (clear_i) begin
      x_d        = '0;
      y_d        = '0;
      dir_d      = DIR_FWD;
      row_base_d = '0;
    end else if (advance_i) begin
      if (row_end_o) begin
        // x stays on the edge pixel; the next row starts there going back.
        y_d        = y_q + ONE;
        dir_d      = ~dir_q;
        row_base_d = row_base_q + ADDR_W'(max_x_i);
      end else if (dir_q == DIR_FWD) begin
        x_d = x_q + ONE;
      end else begin
        x_d = x_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      x_q        <= '0;
      y_q        <= '0;
      dir_q      <= DIR_FWD;
      row_base_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      dir_q      <= dir_d;
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: rtl/serp_frame_writer.sv
// Serpentine frame writer: accepts a pixel stream in boustrophedon order over
// valid/ready and writes each pixel to its raster address y*max_x + x through
// a req/ack write port held until acknowledged.
// Ports:
//   clk, n_rst           : clock, asynchronous active-low reset
//   start, abort         : begin frame (samples max_x/max_y), cancel frame
//   max_x, max_y         : frame dimensions
//   pix_valid/pix_data/pix_ready : input pixel stream
//   mem_wr_req/mem_addr/mem_wdata/mem_ack : frame-buffer write port
//   busy, frame_done     : frame in progress, one-cycle end-of-frame pulse
//   curr_x, curr_y, dir  : position/direction of the next pixel to accept
module serp_frame_writer
  import pixel_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2 * SIZE
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SIZE-1:0]   max_x,
  input  logic [SIZE-1:0]   max_y,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              frame_done,
  output logic [SIZE-1:0]   curr_x,
  output logic [SIZE-1:0]   curr_y,
  output logic              dir
);

  wr_state_t         state_q;
  logic [SIZE-1:0]   max_x_q, max_y_q;
  logic              pix_ready_q, mem_wr_req_q, busy_q, frame_done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              abort_act;
  logic              start_act;
  logic              pos_clear, pos_advance;
  logic              pos_row_end, pos_last;
  logic [ADDR_W-1:0] pos_addr;

  // abort only acts on a running frame and outranks both start and mem_ack.
  assign abort_act   = abort && (state_q != IDLE);
  assign start_act   = start && !abort && (state_q == IDLE);
  assign pos_clear   = start_act || abort_act;
  assign pos_advance = (state_q == WRITE) && mem_ack && !abort;

  serp_pos_tracker #(
    .SIZE   (SIZE),
    .ADDR_W (ADDR_W)
  ) u_pos (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear_i   (pos_clear),
    .advance_i (pos_advance),
    .max_x_i   (max_x_q),
    .max_y_i   (max_y_q),
    .x_o       (curr_x),
    .y_o       (curr_y),
    .dir_o     (dir),
    .row_end_o (pos_row_end),
    .last_o    (pos_last),
    .addr_o    (pos_addr)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      max_x_q      <= '0;
      max_y_q      <= '0;
      pix_ready_q  <= 1'b0;
      mem_wr_req_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (abort_act) begin
        state_q      <= IDLE;
        pix_ready_q  <= 1'b0;
        mem_wr_req_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_act) begin
              max_x_q <= max_x;
              max_y_q <= max_y;
              if ((max_x == '0) || (max_y == '0)) begin
                // Empty frame: report completion without touching memory.
                state_q      <= DONE;
                frame_done_q <= 1'b1;
              end else begin
                state_q     <= ACCEPT;
                pix_ready_q <= 1'b1;
                busy_q      <= 1'b1;
              end
            end
          end
          ACCEPT: begin
            if (pix_valid) begin
              mem_wdata_q  <= pix_data;
              mem_addr_q   <= pos_addr;
              state_q      <= WRITE;
              pix_ready_q  <= 1'b0;
              mem_wr_req_q <= 1'b1;
            end
          end
          WRITE: begin
            if (mem_ack) begin
              mem_wr_req_q <= 1'b0;
              if (pos_last) begin
                state_q      <= DONE;
                busy_q       <= 1'b0;
                frame_done_q <= 1'b1;
              end else begin
                state_q     <= ACCEPT;
                pix_ready_q <= 1'b1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // The row-end flag is consumed inside the tracker; kept here for debug taps.
  logic unused_row_end;
  assign unused_row_end = pos_row_end;

  assign pix_ready  = pix_ready_q;
  assign mem_wr_req = mem_wr_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serp_frame_writer.sv
module tb_serp_frame_writer;

  localparam int SIZE   = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2 * SIZE;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [SIZE-1:0]   max_x = '0;
  logic [SIZE-1:0]   max_y = '0;
  logic              pix_valid = 1'b0;
  logic [DATA_W-1:0] pix_data = '0;
  logic              mem_ack = 1'b0;
  logic              pix_ready, mem_wr_req, busy, frame_done, dir;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [SIZE-1:0]   curr_x, curr_y;

  int checks = 0;
  int errors = 0;

  serp_frame_writer #(.SIZE(SIZE), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .abort      (abort),
    .max_x      (max_x),
    .max_y      (max_y),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .frame_done (frame_done),
    .curr_x     (curr_x),
    .curr_y     (curr_y),
    .dir        (dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, pix_ready, 0);
    chk({tag, "_req"}, mem_wr_req, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_x"}, curr_x, 0);
    chk({tag, "_y"}, curr_y, 0);
    chk({tag, "_dir"}, dir, 0);
  endtask

  // Runs one frame of w x h pixels. The expected write order is built directly
  // from the serpentine rule: even rows left-to-right, odd rows right-to-left.
  task automatic run_frame(input int w, input int h, input int lat_min, input int lat_max,
                           input int vpct, input int abort_idx, input bit start_in_write,
                           input bit fixed_data);
    logic [ADDR_W-1:0] ea[$];
    logic              de[$];
    int                ex[$];
    int                ey[$];
    logic [DATA_W-1:0] pd[$];
    logic [ADDR_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_d;
    int sidx = 0, widx = 0, wait_cnt = 0, lat = 0, cyc = 0;
    int budget = 60 + w * h * 20;
    bit req_seen = 0, fin = 0, ab = 0, injected = 0, stop = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        int px;
        px = (r % 2 == 0) ? c : (w - 1 - c);
        ea.push_back(ADDR_W'(r * w + px));
        de.push_back(1'(r % 2));
        ex.push_back(px);
        ey.push_back(r);
        pd.push_back(fixed_data ? DATA_W'(8'hA0 + r * w + c) : DATA_W'($urandom));
      end
    end
    $display("frame %0dx%0d lat=%0d..%0d abort_idx=%0d", w, h, lat_min, lat_max, abort_idx);
    @(negedge clk);
    max_x = SIZE'(w);
    max_y = SIZE'(h);
    start = 1'b1;
    while (!stop && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start   = 1'b0;
      abort   = 1'b0;
      mem_ack = 1'b0;
      if (ab) begin
        chk("abort_busy", busy, 0);
        chk("abort_req", mem_wr_req, 0);
        chk("abort_ready", pix_ready, 0);
        chk("abort_done", frame_done, 0);
        chk("abort_x", curr_x, 0);
        chk("abort_y", curr_y, 0);
        chk("abort_dir", dir, 0);
        stop = 1;
      end else if (fin) begin
        chk("frame_done", frame_done, 1);
        chk("busy_end", busy, 0);
        chk("final_y", curr_y, SIZE'(h));
        chk("final_dir", dir, h % 2);
        chk("final_x", curr_x, (h % 2 == 1) ? w - 1 : 0);
        chk("writes", widx, w * h);
        stop = 1;
      end else begin
        chk("frame_done_early", frame_done, 0);
        chk("busy", busy, 1);
        if (mem_wr_req) begin
          chk("ready_in_write", pix_ready, 0);
          if (!req_seen) begin
            req_seen = 1;
            wait_cnt = 0;
            lat = $urandom_range(lat_max, lat_min);
            if (widx < w * h) begin
              chk("addr", mem_addr, ea[widx]);
              chk("wdata", mem_wdata, pd[widx]);
              chk("dir", dir, de[widx]);
              chk("curr_x", curr_x, ex[widx]);
              chk("curr_y", curr_y, ey[widx]);
            end else begin
              chk("extra_write", widx, w * h - 1);
            end
            hold_a = mem_addr;
            hold_d = mem_wdata;
            if (start_in_write && !injected) begin
              start = 1'b1;
              max_x = SIZE'(1);
              max_y = SIZE'(1);
              injected = 1;
            end
          end else begin
            chk("addr_hold", mem_addr, hold_a);
            chk("data_hold", mem_wdata, hold_d);
          end
          if (wait_cnt >= lat) begin
            mem_ack = 1'b1;
            req_seen = 0;
            if (widx == abort_idx) begin
              abort = 1'b1;
              ab = 1;
              $display("WR abort addr=%0d data=%02h", mem_addr, mem_wdata);
            end else begin
              $display("WR addr=%0d data=%02h", mem_addr, mem_wdata);
              if (widx == w * h - 1) fin = 1;
            end
            widx++;
          end else begin
            wait_cnt++;
          end
        end
      end
      pix_valid = (sidx < w * h) && ($urandom_range(99, 0) < vpct) && !stop;
      pix_data  = (sidx < w * h) ? pd[sidx] : '0;
      if (pix_ready && pix_valid) sidx++;
    end
    chk("frame_finished", stop, 1);
    pix_valid = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    abort   = 1'b0;
    mem_ack = 1'b0;
    chk("done_one_cycle", frame_done, 0);
    chk("busy_after", busy, 0);
    chk("req_after", mem_wr_req, 0);
  endtask

  task automatic run_empty(input int w, input int h);
    int fd = 0, act = 0;
    @(negedge clk);
    max_x = SIZE'(w);
    max_y = SIZE'(h);
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
      if (frame_done) fd++;
      if (mem_wr_req || busy || pix_ready) act++;
    end
    $display("empty frame %0dx%0d done_pulses=%0d", w, h, fd);
    chk("empty_done_pulses", fd, 1);
    chk("empty_activity", act, 0);
  endtask

  initial begin
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    n_rst = 1'b1;
    @(negedge clk);

    run_frame(3, 2, 1, 1, 100, -1, 0, 1);
    run_frame(4, 3, 3, 3, 50, -1, 0, 0);
    run_empty(0, 3);
    run_empty(2, 0);
    run_frame(1, 3, 0, 2, 70, -1, 0, 0);
    run_frame(4, 4, 0, 2, 80, 4, 0, 0);
    run_frame(4, 4, 0, 1, 100, -1, 0, 0);
    run_frame(2, 2, 1, 2, 100, -1, 1, 0);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    max_x = SIZE'(4);
    max_y = SIZE'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pix_valid = 1'b1;
    pix_data = 8'h5A;
    repeat (7) begin
      mem_ack = mem_wr_req;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    pix_valid = 1'b0;
    chk("pre_reset_busy", busy, 1);
    n_rst = 1'b0;
    #1;
    $display("async reset mid-frame");
    chk_all_zero("midreset");
    @(negedge clk);
    chk("midreset_hold_done", frame_done, 0);
    n_rst = 1'b1;
    run_frame(2, 3, 0, 2, 90, -1, 0, 0);

    for (int k = 0; k < 6; k++) begin
      run_frame($urandom_range(6, 1), $urandom_range(5, 1), 0, 3, $urandom_range(100, 30),
                -1, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
